// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared definitions for the RTC bus sequencers (writer now, reader later):
//   - RTC register addresses and the transfer command byte
//   - bus-phase state enum
//   - helpers that build the hour byte and map a transfer index to an address
// No ports (package).
// -----------------------------------------------------------------------------
package rtc_pkg;

   localparam logic [7:0] RTC_ADDR_SEC  = 8'h21;
   localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
   localparam logic [7:0] RTC_ADDR_HOUR = 8'h23;
   localparam logic [7:0] RTC_ADDR_CMD  = 8'hF2;
   localparam logic [7:0] RTC_CMD_XFER  = 8'hF2;

   typedef enum logic [2:0] {
      IDLE,
      A_SET,
      A_WR,
      D_SET,
      D_WR,
      GAP
   } rtc_phase_e;

   // Bit 7 flags 12 h mode, bit 5 carries PM in that mode; in 24 h mode the
   // tens digit occupies [5:4] and the upper two bits are zero.
   function automatic logic [7:0] rtc_hour_byte(input logic [7:0] hour_bcd,
                                                input logic       ampm,
                                                input logic       format);
      if (format)
         return {1'b1, 1'b0, ampm, hour_bcd[4:0]};
      else
         return {2'b00, hour_bcd[5:0]};
   endfunction

   function automatic logic [7:0] rtc_xfer_addr(input logic [1:0] idx);
      case (idx)
         2'd0:    return RTC_ADDR_SEC;
         2'd1:    return RTC_ADDR_MIN;
         2'd2:    return RTC_ADDR_HOUR;
         default: return RTC_ADDR_CMD;
      endcase
   endfunction

endpackage

// File: rtl/rtc_time_writer_if.sv
// -----------------------------------------------------------------------------
// rtc_time_writer_if
// Pin bundle of the external RTC multiplexed address/data bus.
//   cs_n   chip select, active-low
//   rd_n   read strobe, active-low
//   wr_n   write strobe, active-low
//   ad_n   0 = address phase, 1 = data phase
//   ad_out multiplexed address/data byte
//   ad_oe  pad output enable
// Modports: master (sequencer driving the bus), slave (pad/chip side).
// -----------------------------------------------------------------------------
interface rtc_time_writer_if;

   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic       ad_n;
   logic [7:0] ad_out;
   logic       ad_oe;

   modport master (
      output cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );

   modport slave (
      input cs_n, rd_n, wr_n, ad_n, ad_out, ad_oe
   );

endinterface

// File: rtl/rtc_phase_timer.sv
// -----------------------------------------------------------------------------
// rtc_phase_timer
// Counts 0..T_PHASE-1 while a bus phase is active and flags the last cycle.
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   clear      restart the count (asserted on every state entry)
//   run        a non-idle phase is in progress
//   phase_end  high during the final cycle of the current phase
// -----------------------------------------------------------------------------
module rtc_phase_timer #(
   parameter int T_PHASE = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic phase_end
);

   localparam int              CW   = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
   localparam logic [CW-1:0]   LAST = CW'(T_PHASE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (run)
         cnt <= cnt + CW'(1);
   end

   // With T_PHASE = 1 the count is always 0, so every active cycle ends a phase.
   assign phase_end = run && (cnt == LAST);

endmodule

// File: rtl/rtc_time_writer.sv
// -----------------------------------------------------------------------------
// rtc_time_writer
// On a commit pulse, snapshots the edited time and writes seconds, minutes and
// hours to the external RTC over its multiplexed bus, optionally followed by
// the transfer command (0xF2 -> 0xF2).
//
// Build option: define RTC_WR_CMD_EN to append the transfer command
// (4 transfers); left undefined, only sec/min/hour are written (3 transfers).
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high
//   commit    start request, accepted only when idle
//   hour_bcd  BCD hours (tens [5:4], units [3:0])
//   min_bcd   BCD minutes
//   sec_bcd   BCD seconds
//   ampm      1 = PM (12 h mode only)
//   format    1 = 12 h, 0 = 24 h
//   bus       RTC pin bundle (master side)
//   busy      sequence in progress
//   done      one-cycle pulse at sequence completion
// -----------------------------------------------------------------------------
module rtc_time_writer
   import rtc_pkg::*;
#(
   parameter int T_PHASE = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                commit,
   input  logic [7:0]          hour_bcd,
   input  logic [7:0]          min_bcd,
   input  logic [7:0]          sec_bcd,
   input  logic                ampm,
   input  logic                format,
   rtc_time_writer_if.master   bus,
   output logic                busy,
   output logic                done
);

`ifdef RTC_WR_CMD_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif

   rtc_phase_e state, state_d;
   logic [1:0] idx, idx_d;
   logic       start;
   logic       done_d;
   logic       busy_d;
   logic       phase_end;

   logic [7:0] snap_sec;
   logic [7:0] snap_min;
   logic [7:0] snap_hour;

   logic       cs_n_d;
   logic       wr_n_d;
   logic       ad_n_d;
   logic       ad_oe_d;
   logic [7:0] ad_out_d;
   logic [7:0] xfer_data;

   rtc_phase_timer #(
      .T_PHASE (T_PHASE)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start | phase_end),
      .run       (state != IDLE),
      .phase_end (phase_end)
   );

   always_comb begin
      case (idx_d)
         2'd0:    xfer_data = snap_sec;
         2'd1:    xfer_data = snap_min;
         2'd2:    xfer_data = snap_hour;
         default: xfer_data = RTC_CMD_XFER;
      endcase
   end

   always_comb begin
      state_d = state;
      idx_d   = idx;
      start   = 1'b0;
      done_d  = 1'b0;

      case (state)
         // done still high means the previous sequence just finished; a
         // commit in that cycle is dropped.
         IDLE: begin
            if (commit && !done) begin
               state_d = A_SET;
               idx_d   = 2'd0;
               start   = 1'b1;
            end
         end
         A_SET: if (phase_end) state_d = A_WR;
         A_WR:  if (phase_end) state_d = D_SET;
         D_SET: if (phase_end) state_d = D_WR;
         D_WR:  if (phase_end) state_d = GAP;
         GAP: begin
            if (phase_end) begin
               if (idx == LAST_IDX) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d   = idx + 2'd1;
                  state_d = A_SET;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so that the registered outputs
      // line up with the state they describe.
      cs_n_d   = bus.cs_n;
      wr_n_d   = bus.wr_n;
      ad_n_d   = bus.ad_n;
      ad_oe_d  = bus.ad_oe;
      ad_out_d = bus.ad_out;
      busy_d   = (state_d != IDLE);

      case (state_d)
         A_SET, A_WR: begin
            cs_n_d   = 1'b0;
            ad_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            wr_n_d   = (state_d != A_WR);
            ad_out_d = rtc_xfer_addr(idx_d);
         end
         D_SET, D_WR: begin
            cs_n_d   = 1'b0;
            ad_n_d   = 1'b1;
            ad_oe_d  = 1'b1;
            wr_n_d   = (state_d != D_WR);
            ad_out_d = xfer_data;
         end
         GAP: begin
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            ad_oe_d = 1'b0;
         end
         default: begin
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            ad_n_d  = 1'b1;
            ad_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         idx        <= 2'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bus.cs_n   <= 1'b1;
         bus.wr_n   <= 1'b1;
         bus.ad_n   <= 1'b1;
         bus.ad_oe  <= 1'b0;
         bus.ad_out <= 8'h00;
      end else begin
         state      <= state_d;
         idx        <= idx_d;
         busy       <= busy_d;
         done       <= done_d;
         bus.cs_n   <= cs_n_d;
         bus.wr_n   <= wr_n_d;
         bus.ad_n   <= ad_n_d;
         bus.ad_oe  <= ad_oe_d;
         bus.ad_out <= ad_out_d;
      end
   end

   // Snapshot isolates the running sequence from editor changes.
   always_ff @(posedge clk) begin
      if (start) begin
         snap_sec  <= sec_bcd;
         snap_min  <= min_bcd;
         snap_hour <= rtc_hour_byte(hour_bcd, ampm, format);
      end
   end

   assign bus.rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_time_writer.sv
// -----------------------------------------------------------------------------
// tb_rtc_time_writer
// Drives two writers (T_PHASE = 2 and T_PHASE = 1) and compares every bus cycle
// with a timeline computed from phase arithmetic on the expected transfer list.
// -----------------------------------------------------------------------------
module tb_rtc_time_writer;

   localparam int TP0 = 2;
   localparam int TP1 = 1;

`ifdef RTC_WR_CMD_EN
   localparam int NXFER = 4;
`else
   localparam int NXFER = 3;
`endif

   // {cs_n, rd_n, wr_n, ad_n, ad_oe, busy, done, ad_out}
   localparam logic [14:0] RST_PINS = 15'b1111_0_0_0_00000000;
   localparam logic [14:0] ALL      = 15'h7FFF;

   logic       clk = 1'b0;
   logic       reset;
   logic       commit0;
   logic       commit1;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic       ampm;
   logic       format;
   logic       busy0, done0, busy1, done1;

   int checks = 0;
   int errors = 0;

   rtc_time_writer_if bus0 ();
   rtc_time_writer_if bus1 ();

   rtc_time_writer #(.T_PHASE(TP0)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .commit   (commit0),
      .hour_bcd (hour_bcd),
      .min_bcd  (min_bcd),
      .sec_bcd  (sec_bcd),
      .ampm     (ampm),
      .format   (format),
      .bus      (bus0.master),
      .busy     (busy0),
      .done     (done0)
   );

   rtc_time_writer #(.T_PHASE(TP1)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .commit   (commit1),
      .hour_bcd (hour_bcd),
      .min_bcd  (min_bcd),
      .sec_bcd  (sec_bcd),
      .ampm     (ampm),
      .format   (format),
      .bus      (bus1.master),
      .busy     (busy1),
      .done     (done1)
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] pins(input bit which);
      if (which)
         return {bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.ad_n, bus1.ad_oe, busy1, done1, bus1.ad_out};
      else
         return {bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.ad_n, bus0.ad_oe, busy0, done0, bus0.ad_out};
   endfunction

   // Hour register encoding from plain arithmetic on the editor values.
   function automatic logic [7:0] model_hour(input logic [7:0] h, input logic a, input logic f);
      if (f)
         return 8'h80 + (a ? 8'h20 : 8'h00) + (h % 8'd32);
      else
         return h % 8'd64;
   endfunction

   task automatic check(input string tag, input int k, input logic [14:0] obs,
                        input logic [14:0] exp, input logic [14:0] mask);
      checks++;
      assert ((obs & mask) === (exp & mask))
      else begin
         errors++;
         $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs & mask, exp & mask);
      end
   endtask

   task automatic drive_commit(input bit which);
      if (which) commit1 = 1'b1;
      else       commit0 = 1'b1;
   endtask

   // Starts a sequence with the current inputs and checks every cycle from the
   // first A_SET through the cycle after done. inject_k: cycle at which a
   // second commit and new inputs are applied; reset_k: cycle at which reset is
   // raised (sequence abandoned); commit_on_done: raise commit during done.
   task automatic run_seq(input string tag, input int tp, input bit which,
                          input int inject_k, input int reset_k, input bit commit_on_done);
      logic [7:0]  xa [4];
      logic [7:0]  xd [4];
      logic [14:0] exp, mask;
      int          total, p, x, s;
      logic        cs, wr, adn, oe, bsy, dn;
      logic [7:0]  ad;

      xa[0] = 8'h21;    xd[0] = sec_bcd;
      xa[1] = 8'h22;    xd[1] = min_bcd;
      xa[2] = 8'h23;    xd[2] = model_hour(hour_bcd, ampm, format);
      xa[3] = 8'hF2;    xd[3] = 8'hF2;
      total = NXFER * 5 * tp;

      drive_commit(which);
      for (int k = 0; k <= total + 1; k++) begin
         @(posedge clk);
         #1;
         commit0 = 1'b0;
         commit1 = 1'b0;
         mask = ALL;
         cs = 1'b1; wr = 1'b1; adn = 1'b1; oe = 1'b0; bsy = 1'b0; dn = 1'b0; ad = 8'h00;
         if (k < total) begin
            p   = k / tp;
            x   = p / 5;
            s   = p % 5;
            bsy = 1'b1;
            case (s)
               0, 1: begin cs = 1'b0; adn = 1'b0; oe = 1'b1; wr = (s != 1); ad = xa[x]; end
               2, 3: begin cs = 1'b0; adn = 1'b1; oe = 1'b1; wr = (s != 3); ad = xd[x]; end
               default: begin ad = xd[x]; mask[11] = 1'b0; end
            endcase
         end else begin
            dn   = (k == total);
            mask = mask & ~15'h08FF;
         end
         exp = {cs, 1'b1, wr, adn, oe, bsy, dn, ad};
         check(tag, k, pins(which), exp, mask);

         if (k == inject_k) begin
            drive_commit(which);
            hour_bcd = 8'($urandom);
            min_bcd  = 8'($urandom);
            sec_bcd  = 8'($urandom);
            ampm     = ~ampm;
            format   = ~format;
         end
         if (k == reset_k) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check({tag, "_reset"}, k + 1, pins(which), RST_PINS, ALL);
            return;
         end
         if (commit_on_done && k == total)
            drive_commit(which);
      end
   endtask

   initial begin
      reset    = 1'b1;
      commit0  = 1'b0;
      commit1  = 1'b0;
      hour_bcd = 8'h00;
      min_bcd  = 8'h00;
      sec_bcd  = 8'h00;
      ampm     = 1'b0;
      format   = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle after reset: every pin at its reset value, no strobes.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("idle0", i, pins(1'b0), RST_PINS, ALL);
         check("idle1", i, pins(1'b1), RST_PINS, ALL);
      end

      // 24 h directed write.
      hour_bcd = 8'h23; min_bcd = 8'h59; sec_bcd = 8'h58; ampm = 1'b0; format = 1'b0;
      run_seq("h24", TP0, 1'b0, -1, -1, 1'b0);

      // 12 h PM then AM.
      hour_bcd = 8'h11; ampm = 1'b1; format = 1'b1;
      run_seq("h12pm", TP0, 1'b0, -1, -1, 1'b0);
      ampm = 1'b0;
      run_seq("h12am", TP0, 1'b0, -1, -1, 1'b0);

      // Commit plus input change mid-sequence, and commit during done.
      hour_bcd = 8'h07; min_bcd = 8'h30; sec_bcd = 8'h15; ampm = 1'b0; format = 1'b0;
      run_seq("ignore", TP0, 1'b0, 4, -1, 1'b1);

      // Reset during the second transfer's data strobe, then a clean restart.
      hour_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56; ampm = 1'b1; format = 1'b1;
      run_seq("abort", TP0, 1'b0, -1, 8 * TP0, 1'b0);
      run_seq("restart", TP0, 1'b0, -1, -1, 1'b0);

      // Randomized values, any byte pattern accepted as-is.
      for (int i = 0; i < 4; i++) begin
         hour_bcd = 8'($urandom);
         min_bcd  = 8'($urandom);
         sec_bcd  = 8'($urandom);
         ampm     = 1'($urandom_range(0, 1));
         format   = 1'($urandom_range(0, 1));
         run_seq("rand", TP0, 1'b0, -1, -1, 1'b0);
      end

      // Single-cycle phases.
      for (int i = 0; i < 2; i++) begin
         hour_bcd = 8'($urandom);
         min_bcd  = 8'($urandom);
         sec_bcd  = 8'($urandom);
         ampm     = 1'($urandom_range(0, 1));
         format   = 1'($urandom_range(0, 1));
         run_seq("tp1", TP1, 1'b1, -1, -1, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
